// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg : shared coin values, prices and can-select type
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vending_pkg;

  localparam int C10        = 1;
  localparam int C50        = 5;
  localparam int C100       = 10;

  localparam int PRICE1_DEF = 6;
  localparam int PRICE2_DEF = 10;
  localparam int PRICE3_DEF = 15;
  localparam int CREDIT_MAX = 30;
  localparam int CREDIT_W   = 5;
  localparam int EFF_W      = CREDIT_W + 1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    CAN1 = 2'd1,
    CAN2 = 2'd2,
    CAN3 = 2'd3
  } can_sel_e;

endpackage

`default_nettype wire

// File: rtl/coin_adder.sv
// ---------------------------------------------------------------------------
// coin_adder : sums this cycle's coins onto the credit, rejecting overflow
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module coin_adder
  import vending_pkg::*;
#(
  parameter int CREDIT_LIMIT = CREDIT_MAX
) (
  input  logic [CREDIT_W-1:0] state,
  input  logic                input10,
  input  logic                input50,
  input  logic                inputa0,
  output logic [EFF_W-1:0]    eff
);

  logic [EFF_W-1:0] coin_sum;
  logic [EFF_W-1:0] eff_raw;

  always_comb begin
    coin_sum = '0;
    if (input10) coin_sum = coin_sum + EFF_W'(C10);
    if (input50) coin_sum = coin_sum + EFF_W'(C50);
    if (inputa0) coin_sum = coin_sum + EFF_W'(C100);
    eff_raw = {1'b0, state} + coin_sum;
    // Over the ceiling the whole cycle's coins are refused, not clipped.
    if (eff_raw > EFF_W'(CREDIT_LIMIT)) eff = {1'b0, state};
    else                                eff = eff_raw;
  end

endmodule

`default_nettype wire

// File: rtl/act_vending_unit.sv
// ---------------------------------------------------------------------------
// act_vending_unit : credit accumulator, priority can select, one-cycle change
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module act_vending_unit
  import vending_pkg::*;
#(
  parameter int PRICE1     = PRICE1_DEF,
  parameter int PRICE2     = PRICE2_DEF,
  parameter int PRICE3     = PRICE3_DEF,
  parameter int CREDIT_MAX = vending_pkg::CREDIT_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                input10,
  input  logic                input50,
  input  logic                inputa0,
  input  logic                selectcan1,
  input  logic                selectcan2,
  input  logic                selectcan3,
  output logic                can1,
  output logic                can2,
  output logic                can3,
  output logic [CREDIT_W-1:0] chng
);

  logic [CREDIT_W-1:0] state_q, state_d;
  logic                can1_q, can1_d;
  logic                can2_q, can2_d;
  logic                can3_q, can3_d;
  logic [CREDIT_W-1:0] chng_q, chng_d;

  logic [EFF_W-1:0]    eff;
  logic [EFF_W-1:0]    price;
  can_sel_e            sel;

  coin_adder #(
    .CREDIT_LIMIT (CREDIT_MAX)
  ) u_coin_adder (
    .state   (state_q),
    .input10 (input10),
    .input50 (input50),
    .inputa0 (inputa0),
    .eff     (eff)
  );

  always_comb begin
    sel   = NONE;
    price = '0;
    if (selectcan1) begin
      sel   = CAN1;
      price = EFF_W'(PRICE1);
    end else if (selectcan2) begin
      sel   = CAN2;
      price = EFF_W'(PRICE2);
    end else if (selectcan3) begin
      sel   = CAN3;
      price = EFF_W'(PRICE3);
    end
  end

  always_comb begin
    state_d = eff[CREDIT_W-1:0];
    can1_d  = 1'b0;
    can2_d  = 1'b0;
    can3_d  = 1'b0;
    chng_d  = '0;
    // Short credit keeps eff as the new balance; a vend pays everything out.
    if (sel != NONE && eff >= price) begin
      chng_d  = CREDIT_W'(eff - price);
      state_d = '0;
      case (sel)
        CAN1:    can1_d = 1'b1;
        CAN2:    can2_d = 1'b1;
        CAN3:    can3_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      can1_q  <= 1'b0;
      can2_q  <= 1'b0;
      can3_q  <= 1'b0;
      chng_q  <= '0;
    end else begin
      state_q <= state_d;
      can1_q  <= can1_d;
      can2_q  <= can2_d;
      can3_q  <= can3_d;
      chng_q  <= chng_d;
    end
  end

  assign can1 = can1_q;
  assign can2 = can2_q;
  assign can3 = can3_q;
  assign chng = chng_q;

endmodule

`default_nettype wire

// File: tb/tb_act_vending_unit.sv
// ---------------------------------------------------------------------------
// tb_act_vending_unit : directed self-checking bench for act_vending_unit
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_act_vending_unit;

  logic       clk;
  logic       rst;
  logic       input10, input50, inputa0;
  logic       selectcan1, selectcan2, selectcan3;
  logic       can1, can2, can3;
  logic [4:0] chng;

  int n_checks;
  int n_errors;

  act_vending_unit dut (
    .clk        (clk),
    .rst        (rst),
    .input10    (input10),
    .input50    (input50),
    .inputa0    (inputa0),
    .selectcan1 (selectcan1),
    .selectcan2 (selectcan2),
    .selectcan3 (selectcan3),
    .can1       (can1),
    .can2       (can2),
    .can3       (can3),
    .chng       (chng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    input10 = 0; input50 = 0; inputa0 = 0;
    selectcan1 = 0; selectcan2 = 0; selectcan3 = 0;
  endtask

  // Advance one edge and settle just past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic e1, input logic e2, input logic e3,
                         input logic [4:0] ec);
    chk({tag, ".can1"}, 32'(can1), 32'(e1));
    chk({tag, ".can2"}, 32'(can2), 32'(e2));
    chk({tag, ".can3"}, 32'(can3), 32'(e3));
    chk({tag, ".chng"}, 32'(chng), 32'(ec));
  endtask

  task automatic chk_state(input string tag, input logic [4:0] es);
    chk({tag, ".state"}, 32'(dut.state_q), 32'(es));
  endtask

  // One coin pulse: 0=10, 1=50, 2=100
  task automatic coin(input int kind);
    clr_inputs();
    case (kind)
      0: input10 = 1;
      1: input50 = 1;
      default: inputa0 = 1;
    endcase
    cyc();
    clr_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    clr_inputs();

    // 1. reset hold with toggling inputs
    for (int i = 0; i < 20; i++) begin
      {input10, input50, inputa0, selectcan1, selectcan2, selectcan3} = 6'($urandom);
      cyc();
      chk_out("rst_hold", 0, 0, 0, 5'd0);
      chk_state("rst_hold", 5'd0);
    end
    clr_inputs();
    #3 rst = 1'b1;

    // 2. two 100-coins, held can2 vends once
    coin(2);
    cyc(); cyc();
    coin(2);
    chk_state("t2_credit", 5'd20);
    selectcan2 = 1;
    cyc();
    chk_out("t2_vend", 0, 1, 0, 5'd10);
    chk_state("t2_vend", 5'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("t2_held", 0, 0, 0, 5'd0);
    end
    clr_inputs();

    // 3. insufficient credit keeps balance
    coin(1);
    selectcan3 = 1;
    cyc();
    chk_out("t3_short", 0, 0, 0, 5'd0);
    chk_state("t3_short", 5'd5);
    clr_inputs();
    coin(2);
    chk_state("t3_topup", 5'd15);
    selectcan3 = 1;
    cyc();
    chk_out("t3_vend", 0, 0, 1, 5'd0);
    clr_inputs();

    // 4. simultaneous coins, then priority
    input10 = 1; input50 = 1; inputa0 = 1;
    cyc();
    clr_inputs();
    chk_state("t4_sum", 5'd16);
    selectcan1 = 1; selectcan3 = 1;
    cyc();
    chk_out("t4_prio", 1, 0, 0, 5'd10);
    clr_inputs();

    // 5. saturation
    coin(2); coin(2); coin(2);
    chk_state("t5_full", 5'd30);
    coin(0);
    chk_state("t5_reject", 5'd30);
    selectcan1 = 1;
    cyc();
    chk_out("t5_vend", 1, 0, 0, 5'd24);
    clr_inputs();

    // 6. coin and select together
    coin(1);
    chk_state("t6_pre", 5'd5);
    input50 = 1; selectcan1 = 1;
    cyc();
    chk_out("t6_vend", 1, 0, 0, 5'd4);
    clr_inputs();

    // reset between edges with credit held
    coin(1); coin(1);
    chk_state("t6_build", 5'd10);
    #2 rst = 1'b0;
    #1;
    chk_state("t6_async", 5'd0);
    chk_out("t6_async", 0, 0, 0, 5'd0);
    #2 rst = 1'b1;

    // reset cancels an in-flight vend pulse
    coin(1); coin(1);
    selectcan2 = 1;
    cyc();
    clr_inputs();
    chk_out("t6_pulse", 0, 1, 0, 5'd0);
    #2 rst = 1'b0;
    #1;
    chk_out("t6_cancel", 0, 0, 0, 5'd0);
    cyc();
    chk_state("t6_lost", 5'd0);
    #2 rst = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/act_vending_unit.md
# act_vending_unit

Single-clock beverage vending controller. It accepts 10-, 50- and 100-unit coins, accumulates credit, and vends one of three cans on request. On a vend it returns the change in one cycle. It sits between coin/button front-end logic (synchronized, one-cycle pulses) and the dispenser/change-payout actuators.

## Interface
Parameters:
- PRICE1, 6, can1 price in units of 10 (60)
- PRICE2, 10, can2 price in units of 10 (100)
- PRICE3, 15, can3 price in units of 10 (150)
- CREDIT_MAX, 30, credit ceiling in units of 10 (300)

Ports (positional order fixed as listed):
- clk  in  1  rising-edge clock
- rst  in  1  reset; **one clock; reset is asynchronous and active-low**
- input10  in  1  10-unit coin inserted (high = one coin per sampled cycle)
- input50  in  1  50-unit coin inserted
- inputa0  in  1  100-unit coin inserted
- selectcan1  in  1  request can1
- selectcan2  in  1  request can2
- selectcan3  in  1  request can3
- can1  out  1  dispense can1, one-cycle pulse
- can2  out  1  dispense can2, one-cycle pulse
- can3  out  1  dispense can3, one-cycle pulse
- chng  out  5  change returned, units of 10, valid in the same cycle as a canN pulse, else 0

## Operation
- Internal register `state[4:0]` holds the current credit in units of 10. It is the only FSM state; legal range is 0..CREDIT_MAX.
- Each rising edge:
  - coin_sum = 1·input10 + 5·input50 + 10·inputa0. Simultaneous coins are summed.
  - eff = state + coin_sum, computed at 6 bits.
  - If eff > CREDIT_MAX, all coins this cycle are ignored and eff = state.
- Selection, fixed priority can1 > can2 > can3. Only the highest-priority asserted select is considered; lower selects are ignored that cycle.
  - If eff ≥ price of the chosen can: assert that canN for this cycle, set chng = eff − price, and set state = 0.
  - If eff < price: no vend, chng = 0, state = eff. The credit is kept.
  - If no select is asserted: state = eff, all outputs 0.
- Selects are level-sampled. A held select vends at most once, because credit returns to 0 after a vend; further vends need new credit.
- Coins arriving in a vend cycle count toward eff, so they go into the change.
- Maximum chng is CREDIT_MAX − PRICE1 = 24, which fits in 5 bits.
- At most one of can1..can3 is high in any cycle.

## Timing
- Reset (rst=0, asynchronous): state=0, can1=can2=can3=0, chng=0. Outputs hold these values for as long as rst stays low, and all inputs are ignored.
- Release of reset: the first sampling edge is the first rising clk edge after rst goes high.
- All outputs are registered. canN and chng appear on the edge that samples the select, with a latency of 1 cycle, and last exactly 1 cycle.
- Input holding:
  - A coin input held high for k cycles counts as k coins.
  - The front end must pulse each coin for exactly one cycle.
- Reset mid-vend: the pulse is cancelled immediately and the credit is lost.

## Structure
- Shared package `vending_pkg`:
  - coin values (C10=1, C50=5, C100=10)
  - default prices
  - CREDIT_MAX
  - CREDIT_W=5
  - a can-select enum (NONE, CAN1, CAN2, CAN3)
- One natural sub-module: `coin_adder`. It is combinational: it computes coin_sum and the saturation/reject decision, producing eff. The price compare, priority select and registers stay in the top.

## Test plan
1. **Reset hold:** rst=0 for 20 cycles while toggling all inputs → state=0, all outputs 0 throughout.
2. **Two 100-coins, then can2:**
   - rst=1; pulse inputa0 once, wait 2 cycles, pulse inputa0 again → state=20.
   - Hold selectcan2 for 4 cycles → can2 pulses exactly once with chng=10 in that cycle; state=0; no further pulses.
3. **Insufficient credit:** 50-coin, then selectcan3 → no can3, chng=0, state stays 5. Add a 100-coin and select can3 → can3 pulses, chng=0.
4. **Priority and simultaneous coins:**
   - input10, input50 and inputa0 in the same cycle → state=16.
   - selectcan1 and selectcan3 together → only can1, chng=10.
5. **Saturation:** insert three 100-coins (state=30), then a 10-coin → ignored, state=30. Select can1 → chng=24.
6. **Coin and select in the same cycle, then reset mid-sequence:**
   - With state=5, assert input50 and selectcan1 together → can1 pulses, chng=4.
   - Then build state=10 and drop rst asynchronously between edges → state=0 immediately.
